// File: rtl/control_pipeline_if.sv
// Control-word bundle between the control unit / datapath and control_pipeline.
// master drives the Decode-stage word and ZeroE; slave (the pipeline) drives stage controls.
interface control_pipeline_if #(
   parameter int unsigned AWL = 6,
   parameter int unsigned RAW = 5
);
   logic [AWL-3:0] ALUSelD;
   logic           MtoRFSelD;
   logic           DMWED;
   logic           BranchD;
   logic           ALUInSelD;
   logic           RFDSelD;
   logic           RFWED;
   logic           JumpD;
   logic [RAW-1:0] RsD;
   logic [RAW-1:0] RtD;
   logic [RAW-1:0] RdD;
   logic           ZeroE;

   logic [AWL-3:0] ALUSelE;
   logic           ALUInSelE;
   logic [RAW-1:0] WriteRegE;
   logic [RAW-1:0] WriteRegM;
   logic [RAW-1:0] WriteRegW;
   logic           DMWEM;
   logic           MtoRFSelW;
   logic           RFWEW;
   logic           PCSrcE;
   logic           StallF;
   logic           StallD;
   logic           FlushD;
   logic           FlushE;
   logic [1:0]     ForwardAE;
   logic [1:0]     ForwardBE;

   modport master (
      output ALUSelD, MtoRFSelD, DMWED, BranchD, ALUInSelD, RFDSelD, RFWED, JumpD,
      output RsD, RtD, RdD, ZeroE,
      input  ALUSelE, ALUInSelE, WriteRegE, WriteRegM, WriteRegW, DMWEM, MtoRFSelW, RFWEW,
      input  PCSrcE, StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE
   );

   modport slave (
      input  ALUSelD, MtoRFSelD, DMWED, BranchD, ALUInSelD, RFDSelD, RFWED, JumpD,
      input  RsD, RtD, RdD, ZeroE,
      output ALUSelE, ALUInSelE, WriteRegE, WriteRegM, WriteRegW, DMWEM, MtoRFSelW, RFWEW,
      output PCSrcE, StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE
   );
endinterface

// File: rtl/control_pipeline.sv
// E/M/W control-word pipeline with stall, flush and forwarding-select logic.
// FORWARD_EN: enable Execute operand forwarding; otherwise every RAW hazard stalls.
module control_pipeline #(
   parameter int unsigned AWL = 6,
   parameter int unsigned DWL = 32,
   parameter int unsigned RAW = 5
) (
   input logic               CLK,
   input logic               RST,
   control_pipeline_if.slave bus
);
   typedef struct packed {
      logic [AWL-3:0] alu_sel;
      logic           mtorf;
      logic           dmwe;
      logic           branch;
      logic           alu_in;
      logic           rfd_sel;
      logic           rfwe;
      logic [RAW-1:0] rs;
      logic [RAW-1:0] rt;
      logic [RAW-1:0] rd;
   } e_word_t;

   typedef struct packed {
      logic           mtorf;
      logic           dmwe;
      logic           rfwe;
      logic [RAW-1:0] wreg;
   } m_word_t;

   typedef struct packed {
      logic           mtorf;
      logic           rfwe;
      logic [RAW-1:0] wreg;
   } w_word_t;

   e_word_t e_q, e_d;
   m_word_t m_q, m_d;
   w_word_t w_q, w_d;

   logic [RAW-1:0] write_reg_e;
   logic           pc_src_e;
   logic           hazard;
   logic           flush_e;

`ifdef FORWARD_EN
   // M-stage producer wins over W-stage; register 0 is never forwarded.
   function automatic logic [1:0] fwd_sel(logic [RAW-1:0] r, logic m_we, logic [RAW-1:0] m_reg,
                                          logic w_we, logic [RAW-1:0] w_reg);
      if (r != '0 && m_we && r == m_reg) return 2'b10;
      if (r != '0 && w_we && r == w_reg) return 2'b01;
      return 2'b00;
   endfunction

   logic unused_cfg;
   assign unused_cfg = ^DWL;
`else
   logic unused_cfg;
   assign unused_cfg = ^{DWL, e_q.rs};
`endif

   always_comb begin
      write_reg_e = e_q.rfd_sel ? e_q.rd : e_q.rt;
      pc_src_e    = e_q.branch & bus.ZeroE;
`ifdef FORWARD_EN
      hazard = e_q.mtorf & e_q.rfwe & ((e_q.rt == bus.RsD) | (e_q.rt == bus.RtD));
`else
      hazard = (e_q.rfwe & (write_reg_e != '0) &
                ((write_reg_e == bus.RsD) | (write_reg_e == bus.RtD))) |
               (m_q.rfwe & (m_q.wreg != '0) &
                ((m_q.wreg == bus.RsD) | (m_q.wreg == bus.RtD)));
`endif
      flush_e = hazard | pc_src_e;

      e_d = '0;
      if (!flush_e) begin
         e_d.alu_sel = bus.ALUSelD;
         e_d.mtorf   = bus.MtoRFSelD;
         e_d.dmwe    = bus.DMWED;
         e_d.branch  = bus.BranchD;
         e_d.alu_in  = bus.ALUInSelD;
         e_d.rfd_sel = bus.RFDSelD;
         e_d.rfwe    = bus.RFWED;
         e_d.rs      = bus.RsD;
         e_d.rt      = bus.RtD;
         e_d.rd      = bus.RdD;
      end

      m_d.mtorf = e_q.mtorf;
      m_d.dmwe  = e_q.dmwe;
      m_d.rfwe  = e_q.rfwe;
      m_d.wreg  = write_reg_e;

      w_d.mtorf = m_q.mtorf;
      w_d.rfwe  = m_q.rfwe;
      w_d.wreg  = m_q.wreg;
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         e_q <= '0;
         m_q <= '0;
         w_q <= '0;
      end else begin
         e_q <= e_d;
         m_q <= m_d;
         w_q <= w_d;
      end
   end

   always_comb begin
      bus.ALUSelE   = e_q.alu_sel;
      bus.ALUInSelE = e_q.alu_in;
      bus.WriteRegE = write_reg_e;
      bus.WriteRegM = m_q.wreg;
      bus.WriteRegW = w_q.wreg;
      bus.DMWEM     = m_q.dmwe;
      bus.MtoRFSelW = w_q.mtorf;
      bus.RFWEW     = w_q.rfwe;
      bus.PCSrcE    = pc_src_e;
      // A taken redirect discards the stalled instruction, so it must not hold fetch.
      bus.StallF    = hazard & ~pc_src_e;
      bus.StallD    = hazard & ~pc_src_e;
      bus.FlushE    = flush_e;
      bus.FlushD    = pc_src_e | (bus.JumpD & ~hazard);
`ifdef FORWARD_EN
      bus.ForwardAE = fwd_sel(e_q.rs, m_q.rfwe, m_q.wreg, w_q.rfwe, w_q.wreg);
      bus.ForwardBE = fwd_sel(e_q.rt, m_q.rfwe, m_q.wreg, w_q.rfwe, w_q.wreg);
`else
      bus.ForwardAE = 2'b00;
      bus.ForwardBE = 2'b00;
`endif
   end
endmodule
